// File: rtl/prienc_seq.sv
// Sequential priority encoder: accepts an N-bit request vector and emits the index
// of every set bit, one per output handshake, in MSB-first or LSB-first order.
module prienc_seq #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last
);

  localparam int W = $clog2(N);

  typedef enum logic {IDLE, DRAIN} state_t;

  logic [N-1:0] pend;
  logic [W-1:0] idx;
  logic         last;
  state_t       state;

  assign state = (pend == '0) ? IDLE : DRAIN;

  // Later loop iterations override earlier ones, so the scan direction picks the winner.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) idx = i[W-1:0];
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend[i]) idx = i[W-1:0];
      end
    end
  end

  assign last      = (state == DRAIN) && ((pend & (pend - N'(1))) == '0);
  assign out_valid = (state == DRAIN);
  assign out_idx   = idx;
  assign out_last  = last;
  assign in_ready  = !rst && !abort &&
                     ((state == IDLE) || (out_valid && out_ready && out_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (abort) begin
      pend <= '0;
    end else if (in_valid && in_ready) begin
      pend <= in_vec;
    end else if (out_valid && out_ready) begin
      pend <= pend & ~(N'(1) << out_idx);
    end
  end

endmodule

// File: tb/tb_prienc_seq.sv
// Scoreboard bench for prienc_seq: unit A is N=8 MSB-first, unit B is N=5 LSB-first.
module tb_prienc_seq;

  typedef struct {
    int idx;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, in_valid_a, in_ready_a, abort_a, out_valid_a, out_ready_a, out_last_a;
  logic [7:0] in_vec_a;
  logic [2:0] out_idx_a;
  logic       rst_b, in_valid_b, in_ready_b, abort_b, out_valid_b, out_ready_b, out_last_b;
  logic [4:0] in_vec_b;
  logic [2:0] out_idx_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  int   mode_a = 0;
  int   mode_b = 0;

  prienc_seq #(.N(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_vec(in_vec_a), .abort(abort_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_idx(out_idx_a), .out_last(out_last_a)
  );

  prienc_seq #(.N(5), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_vec(in_vec_b), .abort(abort_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_idx(out_idx_b), .out_last(out_last_b)
  );

  function automatic int q_size(input int u);
    return (u == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic exp_t q_front(input int u);
    return (u == 0) ? q_a[0] : q_b[0];
  endfunction

  function automatic void q_pop(input int u);
    if (u == 0) void'(q_a.pop_front());
    else        void'(q_b.pop_front());
  endfunction

  function automatic void q_clear(input int u);
    if (u == 0) q_a.delete();
    else        q_b.delete();
  endfunction

  // Reference model: list set bits in priority order, flag the final one.
  function automatic void push_vec(input int u, input logic [7:0] v);
    int   n = (u == 0) ? 8 : 5;
    int   lst[$];
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (v[i]) begin
        if (u == 0) lst.push_front(i);
        else        lst.push_back(i);
      end
    end
    for (int k = 0; k < lst.size(); k++) begin
      e.idx  = lst[k];
      e.last = (k == lst.size() - 1);
      if (u == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
  endfunction

  function automatic void cmp(input string name, input int u, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s unit%0d t=%0t: got %0d expected %0d", name, u, $time, act, exp);
    end
  endfunction

  task automatic checkOutput(input int u, input logic r, input logic ab, input logic rdy,
                             input logic vld, input logic ordy, input logic [2:0] idx,
                             input logic last);
    int   sz = q_size(u);
    exp_t e;
    cmp("in_ready", u, int'(rdy), int'(!r && !ab && (sz == 0 || (ordy && sz == 1))));
    cmp("out_valid", u, int'(vld), int'(sz != 0));
    if (sz != 0) begin
      e = q_front(u);
      cmp("out_idx", u, int'(idx), e.idx);
      cmp("out_last", u, int'(last), int'(e.last));
      if (vld && ordy && !r && !ab) q_pop(u);
    end else begin
      cmp("idle_idx", u, int'(idx), 0);
      cmp("idle_last", u, int'(last), 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput(0, rst_a, abort_a, in_ready_a, out_valid_a, out_ready_a, out_idx_a, out_last_a);
      checkOutput(1, rst_b, abort_b, in_ready_b, out_valid_b, out_ready_b, out_idx_b, out_last_b);
    end
  end

  // out_ready drivers: 0 = always ready, 1 = random, 2 = pattern 1,0,0 repeating
  initial begin
    int cnt = 0;
    out_ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode_a)
        1:       out_ready_a = 1'($urandom_range(0, 1));
        2:       begin out_ready_a = (cnt % 3 == 0); cnt++; end
        default: out_ready_a = 1'b1;
      endcase
    end
  end

  initial begin
    out_ready_b = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready_b = (mode_b == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic applyStimulus(input int u, input logic [7:0] v);
    bit ok = 1'b0;
    if (u == 0) begin in_vec_a = v; in_valid_a = 1'b1; end
    else        begin in_vec_b = v[4:0]; in_valid_b = 1'b1; end
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = (u == 0) ? in_ready_a : in_ready_b;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout unit%0d: got in_ready=0 expected 1 within 300 cycles", u);
    end
    @(posedge clk);
    #1;
    if (ok) push_vec(u, v);
    if (u == 0) in_valid_a = 1'b0;
    else        in_valid_b = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    int c = 0;
    while (q_size(u) != 0 && c < 400) begin
      @(posedge clk);
      c++;
    end
    if (q_size(u) != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout unit%0d: got %0d pending expected 0", u, q_size(u));
      q_clear(u);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_abort(input int u);
    @(posedge clk);
    #1;
    if (u == 0) abort_a = 1'b1; else abort_b = 1'b1;
    @(posedge clk);
    #1;
    if (u == 0) abort_a = 1'b0; else abort_b = 1'b0;
    q_clear(u);
  endtask

  task automatic do_reset(input int u);
    @(posedge clk);
    #1;
    if (u == 0) rst_a = 1'b1; else rst_b = 1'b1;
    @(posedge clk);
    #1;
    if (u == 0) rst_a = 1'b0; else rst_b = 1'b0;
    q_clear(u);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] v;
    rst_a = 1'b1; in_valid_a = 1'b0; abort_a = 1'b0; in_vec_a = '0;
    rst_b = 1'b1; in_valid_b = 1'b0; abort_b = 1'b0; in_vec_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    mode_a = 0;
    applyStimulus(0, 8'h92);
    wait_idle(0);
    applyStimulus(1, 8'h12);
    wait_idle(1);

    mode_a = 2;
    applyStimulus(0, 8'hFF);
    wait_idle(0);

    mode_a = 0;
    applyStimulus(0, 8'h81);
    applyStimulus(0, 8'h10);
    wait_idle(0);

    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h01);
    wait_idle(0);
    applyStimulus(1, 8'h1F);
    wait_idle(1);

    applyStimulus(0, 8'hF0);
    do_abort(0);
    wait_idle(0);
    applyStimulus(0, 8'hF0);
    do_reset(0);
    wait_idle(0);
    applyStimulus(1, 8'h1C);
    do_reset(1);
    wait_idle(1);

    mode_a = 1;
    mode_b = 1;
    for (int k = 0; k < 60; k++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 9) == 0) v = 8'h00;
      applyStimulus(k % 2, v);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_abort(k % 2);
      end
    end
    wait_idle(0);
    wait_idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
